id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the RISC-V 5-stage core. It captures decoded operands and control from the decode stage and drives the EX-stage operand multiplexers; its Out_AluSrcB and Out_Valid feed the ALU-B mux Sel and Enable inputs directly. It also contains the load-use hazard detector: it inserts a bubble itself and tells IF/ID to hold.

Parameters:
NrOfBits, 32, datapath width of PC, register operands and immediate.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-low reset.
Stall  input  1  external hold (e.g. memory wait); freezes the register.
Flush  input  1  branch/jump taken in EX; next state becomes a bubble.
In_Valid  input  1  decode-stage instruction is valid.
In_Pc  input  NrOfBits  PC of the decode instruction.
In_Rs1Data, In_Rs2Data  input  NrOfBits  register file read data.
In_Imm  input  NrOfBits  sign-extended immediate.
In_Rs1, In_Rs2, In_Rd  input  5  register indices.
In_RegWrite, In_MemRead, In_MemWrite, In_AluSrcB  input  1  control bits.
In_AluOp  input  4  ALU operation code.
Out_Valid  output  1  EX-stage instruction valid; drives EX mux Enable.
Out_Pc, Out_Rs1Data, Out_Rs2Data, Out_Imm  output  NrOfBits  registered copies.
Out_Rs1, Out_Rs2, Out_Rd  output  5  registered indices.
Out_RegWrite, Out_MemRead, Out_MemWrite, Out_AluSrcB  output  1  registered control.
Out_AluOp  output  4  registered ALU op.
Hazard  output  1  load-use hazard; IF/ID must hold when 1.

Behaviour:
- Reset low (asynchronous): every output register is 0, so Out_Valid=0 and all control bits are 0. Release is sampled on the next rising Clock.
- Hazard is combinational: Out_Valid & Out_MemRead & (Out_Rd!=0) & In_Valid & ((Out_Rd==In_Rs1) | (Out_Rd==In_Rs2)). It is forced to 0 while Stall=1.
- Next-state priority on each rising edge, highest first:
  1. Flush=1: load a bubble. Overrides Stall and Hazard.
  2. Stall=1: hold all registers unchanged.
  3. Hazard=1: load a bubble. The held instruction re-presents on the next cycle.
  4. Otherwise: load all In_* values into the matching Out_* registers. Out_Valid takes In_Valid.
- Bubble definition: Out_Valid, Out_RegWrite, Out_MemRead, Out_MemWrite and Out_AluSrcB are 0; Out_AluOp is 0; all data and index fields are 0. A bubble is never a partial update.
- If In_Valid=0 on a normal load, the control bits are still captured as-is. Downstream qualifies them with Out_Valid.
- Latency: exactly one cycle from In_* to Out_*. No combinational path from In_* to Out_*, except Hazard, which reads In_Rs1, In_Rs2 and In_Valid.
- Hazard lasts one cycle per load-use pair: after the bubble, Out_MemRead=0, so Hazard drops.
- Reset asserted mid-operation clears state immediately regardless of Stall or Flush.

Optional Feature:
Macro ID_EX_BUBBLE_COUNT_EN.
- Defined: adds output Bubble_Count, 32 bits, registered, reset to 0.
  - Increments by 1 on every edge where a bubble is loaded (Flush or Hazard path), not on Stall.
  - Saturates at 32'hFFFF_FFFF.
- Not defined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold Reset=0 with In_Valid=1, In_Pc=32'h100 for 3 edges → all outputs 0. Release, then one edge → Out_Valid=1, Out_Pc=32'h100.
- Pass-through: load In_Rs1Data=32'hDEAD_BEEF, In_Imm=32'hFFFF_FFF0, In_AluSrcB=1, In_AluOp=4'h3 → exactly one edge later the outputs match; the EX mux selects Imm.
- Stall: Stall=1 for 4 cycles while the inputs change each cycle → outputs keep the pre-stall values and Hazard=0. Release → next edge loads the current inputs.
- Load-use: EX holds lw with Out_Rd=5, Out_MemRead=1; decode presents In_Rs2=5, In_Valid=1 → Hazard=1 combinationally. Next edge: bubble (Out_Valid=0) and Hazard=0. Following edge loads the dependent instruction.
- Rd=x0 load: Out_Rd=0, Out_MemRead=1, In_Rs1=0 → Hazard stays 0.
- Flush+Stall+Hazard together: assert all three → next edge gives a bubble. With ID_EX_BUBBLE_COUNT_EN, Bubble_Count goes 0→1; a subsequent 3-cycle Stall leaves it at 1.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with built-in load-use hazard detection and bubble insertion.
// Optional macro ID_EX_BUBBLE_COUNT_EN adds a saturating Bubble_Count output.
module id_ex_pipe_reg #(
    parameter int NrOfBits = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                In_Valid,
    input  logic [NrOfBits-1:0] In_Pc,
    input  logic [NrOfBits-1:0] In_Rs1Data,
    input  logic [NrOfBits-1:0] In_Rs2Data,
    input  logic [NrOfBits-1:0] In_Imm,
    input  logic [4:0]          In_Rs1,
    input  logic [4:0]          In_Rs2,
    input  logic [4:0]          In_Rd,
    input  logic                In_RegWrite,
    input  logic                In_MemRead,
    input  logic                In_MemWrite,
    input  logic                In_AluSrcB,
    input  logic [3:0]          In_AluOp,
    output logic                Out_Valid,
    output logic [NrOfBits-1:0] Out_Pc,
    output logic [NrOfBits-1:0] Out_Rs1Data,
    output logic [NrOfBits-1:0] Out_Rs2Data,
    output logic [NrOfBits-1:0] Out_Imm,
    output logic [4:0]          Out_Rs1,
    output logic [4:0]          Out_Rs2,
    output logic [4:0]          Out_Rd,
    output logic                Out_RegWrite,
    output logic                Out_MemRead,
    output logic                Out_MemWrite,
    output logic                Out_AluSrcB,
    output logic [3:0]          Out_AluOp,
`ifdef ID_EX_BUBBLE_COUNT_EN
    output logic                Hazard,
    output logic [31:0]         Bubble_Count
`else
    output logic                Hazard
`endif
);

    typedef struct packed {
        logic                valid;
        logic [NrOfBits-1:0] pc;
        logic [NrOfBits-1:0] rs1_data;
        logic [NrOfBits-1:0] rs2_data;
        logic [NrOfBits-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src_b;
        logic [3:0]          alu_op;
    } stage_t;

    stage_t stage_d, stage_q;
    stage_t in_stage;
    logic   hazard;
    logic   load_bubble;

    // Valid semantics: Out_Valid qualifies every Out_* field; there is no ready,
    // back-pressure comes only through Stall (external) and Hazard (to IF/ID).
    always_comb begin
        in_stage = '{valid: In_Valid, pc: In_Pc, rs1_data: In_Rs1Data,
                     rs2_data: In_Rs2Data, imm: In_Imm, rs1: In_Rs1, rs2: In_Rs2,
                     rd: In_Rd, reg_write: In_RegWrite, mem_read: In_MemRead,
                     mem_write: In_MemWrite, alu_src_b: In_AluSrcB, alu_op: In_AluOp};

        hazard = !Stall && stage_q.valid && stage_q.mem_read && (stage_q.rd != 5'd0)
                 && In_Valid && ((stage_q.rd == In_Rs1) || (stage_q.rd == In_Rs2));

        stage_d     = stage_q;
        load_bubble = 1'b0;
        if (Flush) begin
            stage_d     = '0;
            load_bubble = 1'b1;
        end else if (Stall) begin
            stage_d = stage_q;
        end else if (hazard) begin
            stage_d     = '0;
            load_bubble = 1'b1;
        end else begin
            stage_d = in_stage;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign Hazard       = hazard;
    assign Out_Valid    = stage_q.valid;
    assign Out_Pc       = stage_q.pc;
    assign Out_Rs1Data  = stage_q.rs1_data;
    assign Out_Rs2Data  = stage_q.rs2_data;
    assign Out_Imm      = stage_q.imm;
    assign Out_Rs1      = stage_q.rs1;
    assign Out_Rs2      = stage_q.rs2;
    assign Out_Rd       = stage_q.rd;
    assign Out_RegWrite = stage_q.reg_write;
    assign Out_MemRead  = stage_q.mem_read;
    assign Out_MemWrite = stage_q.mem_write;
    assign Out_AluSrcB  = stage_q.alu_src_b;
    assign Out_AluOp    = stage_q.alu_op;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_count_d, bubble_count_q;

    // Saturating: holds at all-ones once reached.
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (load_bubble && (bubble_count_q != 32'hFFFF_FFFF)) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bubble_count_q <= 32'd0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    assign Bubble_Count = bubble_count_q;
`else
    logic unused_load_bubble;
    assign unused_load_bubble = load_bubble;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed steps plus randomized traffic
// against a field-level reference model of the ID/EX register.
module tb_id_ex_pipe_reg;

    localparam int N = 32;
    localparam int W = 4 * N + 24;

    logic         Clock = 1'b0;
    logic         Reset, Stall, Flush, In_Valid;
    logic [N-1:0] In_Pc, In_Rs1Data, In_Rs2Data, In_Imm;
    logic [4:0]   In_Rs1, In_Rs2, In_Rd;
    logic         In_RegWrite, In_MemRead, In_MemWrite, In_AluSrcB;
    logic [3:0]   In_AluOp;
    logic         Out_Valid;
    logic [N-1:0] Out_Pc, Out_Rs1Data, Out_Rs2Data, Out_Imm;
    logic [4:0]   Out_Rs1, Out_Rs2, Out_Rd;
    logic         Out_RegWrite, Out_MemRead, Out_MemWrite, Out_AluSrcB;
    logic [3:0]   Out_AluOp;
    logic         Hazard;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0]  Bubble_Count;
`endif

    id_ex_pipe_reg #(.NrOfBits(N)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .In_Valid(In_Valid), .In_Pc(In_Pc), .In_Rs1Data(In_Rs1Data),
        .In_Rs2Data(In_Rs2Data), .In_Imm(In_Imm), .In_Rs1(In_Rs1), .In_Rs2(In_Rs2),
        .In_Rd(In_Rd), .In_RegWrite(In_RegWrite), .In_MemRead(In_MemRead),
        .In_MemWrite(In_MemWrite), .In_AluSrcB(In_AluSrcB), .In_AluOp(In_AluOp),
        .Out_Valid(Out_Valid), .Out_Pc(Out_Pc), .Out_Rs1Data(Out_Rs1Data),
        .Out_Rs2Data(Out_Rs2Data), .Out_Imm(Out_Imm), .Out_Rs1(Out_Rs1),
        .Out_Rs2(Out_Rs2), .Out_Rd(Out_Rd), .Out_RegWrite(Out_RegWrite),
        .Out_MemRead(Out_MemRead), .Out_MemWrite(Out_MemWrite),
        .Out_AluSrcB(Out_AluSrcB), .Out_AluOp(Out_AluOp),
`ifdef ID_EX_BUBBLE_COUNT_EN
        .Hazard(Hazard), .Bubble_Count(Bubble_Count)
`else
        .Hazard(Hazard)
`endif
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    logic [W-1:0] dut_vec;
    assign dut_vec = {Out_Valid, Out_Pc, Out_Rs1Data, Out_Rs2Data, Out_Imm,
                      Out_Rs1, Out_Rs2, Out_Rd, Out_RegWrite, Out_MemRead,
                      Out_MemWrite, Out_AluSrcB, Out_AluOp};

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_out = '0;
    logic         m_valid = 1'b0, m_mem_read = 1'b0;
    logic [4:0]   m_rd = 5'd0;
    logic [31:0]  m_cnt = 32'd0;
    int           vectors = 0;
    int           fails = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_out = '0; m_valid = 1'b0; m_mem_read = 1'b0; m_rd = 5'd0;
    endtask

    // One clock: entered just after a rising edge with inputs already driven.
    task automatic cycle(input string tag);
        logic exp_haz;
        logic [W-1:0] in_v;
        logic [W-1:0] exp_v;
        in_v = {In_Valid, In_Pc, In_Rs1Data, In_Rs2Data, In_Imm, In_Rs1, In_Rs2,
                In_Rd, In_RegWrite, In_MemRead, In_MemWrite, In_AluSrcB, In_AluOp};
        exp_haz = Reset && !Stall && m_valid && m_mem_read && (m_rd != 5'd0) && In_Valid
                  && ((m_rd == In_Rs1) || (m_rd == In_Rs2));
        #2;
        chk({tag, "_hazard"}, W'(Hazard), W'(exp_haz));
        if (!Reset) begin
            model_clear(); m_cnt = 32'd0;
        end else if (Flush || (!Stall && exp_haz)) begin
            model_clear();
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (!Stall) begin
            m_out = in_v; m_valid = In_Valid; m_mem_read = In_MemRead; m_rd = In_Rd;
        end
        exp_q.push_back(m_out);
        @(posedge Clock);
        #1;
        exp_v = exp_q.pop_front();
        chk({tag, "_out"}, dut_vec, exp_v);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk({tag, "_bcount"}, W'(Bubble_Count), W'(m_cnt));
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic drive_rand(input int rmax);
        In_Valid    = 1'($urandom_range(0, 3) != 0);
        In_Pc       = $urandom;
        In_Rs1Data  = $urandom;
        In_Rs2Data  = $urandom;
        In_Imm      = $urandom;
        In_Rs1      = 5'($urandom_range(0, rmax));
        In_Rs2      = 5'($urandom_range(0, rmax));
        In_Rd       = 5'($urandom_range(0, rmax));
        In_RegWrite = 1'($urandom_range(0, 1));
        In_MemRead  = 1'($urandom_range(0, 1));
        In_MemWrite = 1'($urandom_range(0, 1));
        In_AluSrcB  = 1'($urandom_range(0, 1));
        In_AluOp    = 4'($urandom_range(0, 15));
    endtask

    task automatic drive_lw(input logic [4:0] rd);
        drive_rand(31);
        In_Valid = 1'b1; In_MemRead = 1'b1; In_Rd = rd;
        Stall = 1'b0; Flush = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] cnt_before;
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
        drive_rand(31);
        In_Valid = 1'b1; In_Pc = 32'h100;
        #1;
        chk("reset_initial", dut_vec, '0);
        @(posedge Clock); #1;
        repeat (3) cycle("reset_hold");

        Reset = 1'b1; In_MemRead = 1'b0;
        cycle("reset_release");
        chk("release_valid", W'(Out_Valid), W'(1'b1));
        chk("release_pc", W'(Out_Pc), W'(32'h100));

        // Pass-through with immediate selected on the ALU-B mux
        drive_rand(31);
        In_Valid = 1'b1; In_Rs1Data = 32'hDEAD_BEEF; In_Imm = 32'hFFFF_FFF0;
        In_AluSrcB = 1'b1; In_AluOp = 4'h3;
        cycle("pass");
        chk("pass_rs1data", W'(Out_Rs1Data), W'(32'hDEAD_BEEF));
        chk("pass_alub_mux", W'(Out_AluSrcB ? Out_Imm : Out_Rs2Data), W'(32'hFFFF_FFF0));
        chk("pass_aluop", W'(Out_AluOp), W'(4'h3));

        // Stall with changing inputs
        Stall = 1'b1;
        repeat (4) begin
            drive_rand(31);
            cycle("stall");
        end
        Stall = 1'b0;
        drive_rand(31);
        cycle("stall_release");

        // Load-use: lw x5 then consumer reading x5 on rs2
        Flush = 1'b1; cycle("pre_lw_flush"); Flush = 1'b0;
        drive_lw(5'd5);
        cycle("lw");
        drive_rand(31);
        In_Valid = 1'b1; In_Rs1 = 5'd7; In_Rs2 = 5'd5;
        #1;
        chk("load_use_hazard_hi", W'(Hazard), W'(1'b1));
        cycle("load_use_bubble");
        chk("load_use_bubble_valid", W'(Out_Valid), W'(1'b0));
        cycle("load_use_dep");
        chk("load_use_dep_rs2", W'(Out_Rs2), W'(5'd5));

        // Load to x0 never hazards
        drive_lw(5'd0);
        cycle("lw_x0");
        drive_rand(31);
        In_Valid = 1'b1; In_Rs1 = 5'd0; In_Rs2 = 5'd0;
        #1;
        chk("x0_hazard_lo", W'(Hazard), W'(1'b0));
        cycle("x0_dep");

        // Flush + Stall + dependent consumer together
        drive_lw(5'd5);
        cycle("lw_combo");
        drive_rand(31);
        In_Valid = 1'b1; In_Rs1 = 5'd5;
        Stall = 1'b1; Flush = 1'b1;
        cnt_before = m_cnt;
        cycle("combo_bubble");
        chk("combo_valid", W'(Out_Valid), W'(1'b0));
        chk("combo_cnt_step", W'(m_cnt - cnt_before), W'(32'd1));
        Flush = 1'b0;
        repeat (3) cycle("combo_stall");
        Stall = 1'b0;

        // Asynchronous reset mid-operation, between clock edges
        drive_rand(31); In_Valid = 1'b1;
        cycle("pre_async");
        #1;
        Stall = 1'b1; Flush = 1'b1; Reset = 1'b0;
        #1;
        chk("async_reset_clear", dut_vec, '0);
        model_clear(); m_cnt = 32'd0;
        cycle("async_reset_hold");
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;

        // Randomized traffic with a small register range to provoke hazards
        for (int i = 0; i < 300; i++) begin
            drive_rand(3);
            Stall = 1'($urandom_range(0, 7) == 0);
            Flush = 1'($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
